// File: rtl/text_pixel_gen.sv
// text_pixel_gen
//   Text-mode pixel generator. Converts each pixel coordinate from the VGA
//   timing generator into a text-buffer fetch, then a character-ROM fetch,
//   then selects the glyph bit for the pixel and overlays a blinking
//   underline cursor. The de/hsync/vsync sideband is delayed to line up
//   with the pixel stream (fixed latency of 5 clocks, no stalls).
//
// Ports
//   clk, reset            pixel clock; asynchronous active-high reset
//   hcount, vcount        pixel coordinates (valid while de_in = 1)
//   de_in                 visible-area flag
//   hsync_in, vsync_in    syncs from the timing generator (SYNC_POL active)
//   tram_addr, tram_data  text buffer address out / character code in (1-cycle RAM)
//   rom_ad, rom_dout      chr_rom address {code, glyph_row} out / glyph row in
//   cursor_en/col/row     cursor control, latched on the vsync leading edge
//   pixel                 foreground (1) / background (0)
//   de_out, hsync_out,
//   vsync_out             sideband delayed to match pixel
module text_pixel_gen #(
    parameter int   COLS         = 80,
    parameter int   ROWS         = 60,
    parameter int   H_BITS       = 10,
    parameter int   V_BITS       = 10,
    parameter int   ADDR_BITS    = 13,
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_POL     = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [H_BITS-1:0]    hcount,
    input  logic [V_BITS-1:0]    vcount,
    input  logic                 de_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic [ADDR_BITS-1:0] tram_addr,
    input  logic [7:0]           tram_data,
    output logic [10:0]          rom_ad,
    input  logic [7:0]           rom_dout,
    input  logic                 cursor_en,
    input  logic [6:0]           cursor_col,
    input  logic [5:0]           cursor_row,
    output logic                 pixel,
    output logic                 de_out,
    output logic                 hsync_out,
    output logic                 vsync_out
);

    localparam int CW = H_BITS - 3;
    localparam int RW = V_BITS - 3;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    // Current-pixel decode
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [2:0]           col_lo;
    logic [2:0]           row_lo;
    logic                 in_text;
    logic                 cur;
    logic                 vs_lead;
    logic [ADDR_BITS-1:0] addr_next;

    // Frame-rate state
    logic                 vs_prev;
    logic [FW-1:0]        fcnt;
    logic                 blink;
    logic                 cur_en_l;
    logic [6:0]           cur_col_l;
    logic [5:0]           cur_row_l;

    // Sideband delay line; index 3 is the value sampled four edges ago,
    // the fifth stage is the output register itself.
    logic [3:0]           de_sr;
    logic [3:0]           hs_sr;
    logic [3:0]           vs_sr;
    logic [3:0]           it_sr;
    logic [3:0]           cur_sr;
    logic [2:0]           col_lo_d [4];
    logic [2:0]           row_lo_d [2];

    always_comb begin
        col       = hcount[H_BITS-1:3];
        row       = vcount[V_BITS-1:3];
        col_lo    = hcount[2:0];
        row_lo    = vcount[2:0];
        in_text   = de_in && (int'(col) < COLS) && (int'(row) < ROWS);
        addr_next = ADDR_BITS'(row) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
        // Two-line underline on the bottom of the cursor cell
        cur       = cur_en_l && blink
                    && (int'(col) == int'(cur_col_l))
                    && (int'(row) == int'(cur_row_l))
                    && (row_lo >= 3'd6);
        vs_lead   = (vsync_in == SYNC_POL) && (vs_prev != SYNC_POL);
    end

    // Cursor latch and blink counter advance only on the vsync leading edge,
    // so cursor changes never tear mid-frame. vs_prev resets to the active
    // level: a vsync already active at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev   <= SYNC_POL;
            fcnt      <= '0;
            blink     <= 1'b0;
            cur_en_l  <= 1'b0;
            cur_col_l <= '0;
            cur_row_l <= '0;
        end else begin
            vs_prev <= vsync_in;
            if (vs_lead) begin
                cur_en_l  <= cursor_en;
                cur_col_l <= cursor_col;
                cur_row_l <= cursor_row;
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    blink <= ~blink;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    // E1 address, E3 ROM address, E5 pixel; E2/E4 are the external RAM/ROM reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tram_addr <= '0;
            rom_ad    <= '0;
            pixel     <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= ~SYNC_POL;
            vsync_out <= ~SYNC_POL;
            de_sr     <= '0;
            hs_sr     <= {4{~SYNC_POL}};
            vs_sr     <= {4{~SYNC_POL}};
            it_sr     <= '0;
            cur_sr    <= '0;
            for (int unsigned i = 0; i < 4; i++) col_lo_d[i] <= '0;
            for (int unsigned i = 0; i < 2; i++) row_lo_d[i] <= '0;
        end else begin
            tram_addr <= in_text ? addr_next : '0;

            de_sr  <= {de_sr[2:0], de_in};
            hs_sr  <= {hs_sr[2:0], hsync_in};
            vs_sr  <= {vs_sr[2:0], vsync_in};
            it_sr  <= {it_sr[2:0], in_text};
            cur_sr <= {cur_sr[2:0], cur};
            col_lo_d[0] <= col_lo;
            for (int unsigned i = 1; i < 4; i++) col_lo_d[i] <= col_lo_d[i-1];
            row_lo_d[0] <= row_lo;
            row_lo_d[1] <= row_lo_d[0];

            rom_ad <= {tram_data, row_lo_d[1]};

            // Bit 7 of the glyph row is the leftmost pixel; in_text masks
            // blanking and out-of-range cells regardless of ROM content.
            pixel     <= (rom_dout[3'd7 - col_lo_d[3]] ^ cur_sr[3]) & it_sr[3];
            de_out    <= de_sr[3];
            hsync_out <= hs_sr[3];
            vsync_out <= vs_sr[3];
        end
    end

endmodule

// File: tb/tb_text_pixel_gen.sv
module tb_text_pixel_gen;

    localparam int   COLS  = 80;
    localparam int   ROWS  = 60;
    localparam int   BF    = 30;
    localparam logic POL   = 1'b0;
    localparam logic INACT = ~POL;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        de_in = 1'b0;
    logic        hsync_in = INACT;
    logic        vsync_in = INACT;
    logic [12:0] tram_addr;
    logic [7:0]  tram_data;
    logic [10:0] rom_ad;
    logic [7:0]  rom_dout;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic        pixel;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    always #5 clk = ~clk;

    text_pixel_gen #(
        .COLS(COLS), .ROWS(ROWS), .H_BITS(10), .V_BITS(10),
        .ADDR_BITS(13), .BLINK_FRAMES(BF), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .tram_addr(tram_addr), .tram_data(tram_data),
        .rom_ad(rom_ad), .rom_dout(rom_dout),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .pixel(pixel), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Text RAM and character ROM, both with a one-cycle registered read
    logic [7:0] ram [8192];
    logic [7:0] rom [2048];
    always @(posedge clk) begin
        tram_data <= ram[tram_addr];
        rom_dout  <= rom[rom_ad];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-pixel expected output from the screen rules
    typedef struct {
        logic pix;
        logic de;
        logic hs;
        logic vs;
        bit   st;
        int   x;
        int   y;
    } ent_t;

    ent_t q[$];
    bit   m_prev;
    int   m_fcnt;
    bit   m_blink;
    bit   m_en;
    int   m_col;
    int   m_row;
    bit   cur_st = 1'b0;
    int   hit2, hit3, hitup;
    int   shown_col = 0;

    function automatic ent_t model_sample();
        ent_t e;
        int x = int'(hcount);
        int y = int'(vcount);
        int c = x / 8;
        int r = y / 8;
        bit it = de_in && c < COLS && r < ROWS;
        bit cr = m_en && m_blink && c == m_col && r == m_row && (y % 8) >= 6;
        logic [7:0] g;
        e.pix = 1'b0;
        if (it) begin
            g = rom[int'(ram[r * COLS + c]) * 8 + y % 8];
            e.pix = g[7 - x % 8] ^ cr;
        end
        e.de = de_in;
        e.hs = hsync_in;
        e.vs = vsync_in;
        e.st = 1'b0;
        e.x  = x;
        e.y  = y;
        return e;
    endfunction

    task automatic model_reset();
        ent_t e;
        m_prev  = POL;
        m_fcnt  = 0;
        m_blink = 1'b0;
        m_en    = 1'b0;
        m_col   = 0;
        m_row   = 0;
        q.delete();
        e = '{pix:1'b0, de:1'b0, hs:INACT, vs:INACT, st:1'b0, x:0, y:0};
        repeat (4) q.push_back(e);
    endtask

    task automatic tick();
        ent_t e;
        ent_t o;
        int   ea;
        @(posedge clk);
        e = model_sample();
        e.st = cur_st;
        q.push_back(e);
        ea = (de_in && hcount / 8 < COLS && vcount / 8 < ROWS)
             ? int'(vcount / 8) * COLS + int'(hcount / 8) : 0;
        if (vsync_in == POL && m_prev != POL) begin
            m_en  = cursor_en;
            m_col = int'(cursor_col);
            m_row = int'(cursor_row);
            if (m_fcnt == BF - 1) begin
                m_fcnt  = 0;
                m_blink = !m_blink;
            end else begin
                m_fcnt++;
            end
        end
        m_prev = vsync_in;
        #1;
        check("tram_addr", tram_addr, ea);
        if (q.size() > 4) begin
            o = q.pop_front();
            check("pixel", pixel, o.pix);
            check("de_out", de_out, o.de);
            check("hsync_out", hsync_out, o.hs);
            check("vsync_out", vsync_out, o.vs);
            if (o.st) begin
                if (o.x >= 16 && o.x < 24 && o.y >= 14) hit2 += int'(pixel);
                if (o.x >= 24 && o.x < 32 && o.y >= 14) hit3 += int'(pixel);
                if (o.x >= 16 && o.x < 32 && o.y < 14)  hitup += int'(pixel);
            end
        end
    endtask

    task automatic drive(input int x, input int y, input bit de, input bit hs,
                         input bit vs, input bit st);
        hcount   = 10'(x);
        vcount   = 10'(y);
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        cur_st   = st;
        tick();
    endtask

    // Assert reset between clock edges and check the immediate output values
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_pixel", pixel, 0);
        check("rst_de", de_out, 0);
        check("rst_hsync", hsync_out, INACT);
        check("rst_vsync", vsync_out, INACT);
        check("rst_tram_addr", tram_addr, 0);
        check("rst_rom_ad", rom_ad, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        shown_col = 0;
    endtask

    // Compressed frame: cursor rows 1 (y 8..15), columns 0..3, a random line, vsync
    task automatic frame(input int f, input bit move);
        int  e2, e3;
        bit  on;
        hit2 = 0;
        hit3 = 0;
        hitup = 0;
        for (int y = 8; y < 16; y++) begin
            if (move && y == 12) cursor_col = 7'd3;
            for (int x = 0; x < 32; x++) drive(x, y, 1'b1, INACT, INACT, 1'b1);
            for (int k = 0; k < 8; k++)
                drive(0, y, 1'b0, (k >= 2 && k < 6) ? POL : INACT, INACT, 1'b0);
        end
        for (int k = 0; k < 24; k++)
            drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), INACT, 1'b0);
        for (int k = 0; k < 10; k++) drive(0, 0, 1'b0, INACT, POL, 1'b0);
        on = ((f / BF) % 2) == 1;
        e2 = (on && shown_col == 2) ? 16 : 0;
        e3 = (on && shown_col == 3) ? 16 : 0;
        check("cursor_col2", hit2, e2);
        check("cursor_col3", hit3, e3);
        check("cursor_upper", hitup, 0);
        shown_col = int'(cursor_col);
    endtask

    initial begin
        logic [0:7] gexp;
        logic       pl [13];
        for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        ram[0]  = 8'h41;
        rom[11'h208] = 8'h30;
        ram[82] = 8'h20;
        ram[83] = 8'h20;
        for (int i = 0; i < 8; i++) rom[32 * 8 + i] = 8'h00;

        do_reset();

        // Glyph fetch for 'A' row 0
        gexp = 8'b0011_0000;
        for (int k = 0; k < 13; k++) begin
            if (k < 8) drive(k, 0, 1'b1, INACT, INACT, 1'b0);
            else       drive(0, 0, 1'b0, INACT, INACT, 1'b0);
            if (k == 2) check("rom_ad_A", rom_ad, 11'h208);
            pl[k] = pixel;
        end
        for (int i = 0; i < 8; i++) check("glyph_A", pl[i + 4], gexp[i]);

        // Address boundary: last cell and first column past the text area
        drive(632, 472, 1'b1, INACT, INACT, 1'b0);
        check("addr_last_cell", tram_addr, 4799);
        drive(640, 472, 1'b1, INACT, INACT, 1'b0);
        check("addr_out_of_range", tram_addr, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 1'b0, INACT, INACT, 1'b0);
        check("pixel_out_of_range", pixel, 0);

        // Blink over 92 frames; cursor column changes mid-frame in frame 58
        cursor_en  = 1'b1;
        cursor_row = 6'd1;
        cursor_col = 7'd2;
        for (int f = 0; f < 92; f++) frame(f, f == 58);

        // Reset in the middle of a line, then confirm the blink restarts
        for (int x = 0; x < 10; x++) drive(x, 8, 1'b1, INACT, INACT, 1'b0);
        do_reset();
        for (int f = 0; f < 32; f++) frame(f, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
